// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake. Single-cycle ops complete on
// the accepting edge; opc 8 runs a W-iteration unsigned shift-add multiply.
module alu_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [3:0]   opc,
    input  logic         inc,
    output logic [W-1:0] w,
    output logic         zer,
    output logic         neg,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    localparam int             CW      = $clog2(W) + 1;
    localparam logic [CW-1:0]  LAST    = CW'(W - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [W-1:0]   MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]   ONE     = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   w_reg, w_next;
    logic           zer_reg, zer_next;
    logic           neg_reg, neg_next;
    logic           ovf_reg, ovf_next;
    logic           done_reg, done_next;
    logic [W-1:0]   acc_reg, acc_next;
    logic [W-1:0]   mcand_reg, mcand_next;
    logic [W-1:0]   mplier_reg, mplier_next;
    logic [CW-1:0]  cnt_reg, cnt_next;

    logic [W-1:0]   b_half;
    logic [W-1:0]   alu_res;
    logic           alu_ovf;
    logic [W-1:0]   acc_sum;

    // Single-cycle datapath works straight from the inputs: the result is
    // registered on the accepting edge, which is the operand capture.
    always_comb begin
        b_half  = {in_b[W-1], in_b[W-1:1]};
        alu_res = '0;
        alu_ovf = 1'b0;
        case (opc)
            4'd0: begin
                alu_res = -in_a;
                alu_ovf = (in_a == MIN_VAL);
            end
            4'd1: begin
                alu_res = in_a + ONE;
                alu_ovf = ~in_a[W-1] & alu_res[W-1];
            end
            4'd2: begin
                alu_res = in_a + in_b + {{(W-1){1'b0}}, inc};
                alu_ovf = (in_a[W-1] == in_b[W-1]) && (alu_res[W-1] != in_a[W-1]);
            end
            4'd3: begin
                alu_res = in_a + b_half;
                alu_ovf = (in_a[W-1] == b_half[W-1]) && (alu_res[W-1] != in_a[W-1]);
            end
            4'd4: alu_res = in_a & in_b;
            4'd5: alu_res = in_a | in_b;
            4'd6: alu_res = {in_a[W/2-1:0], in_b[W/2-1:0]};
            default: ;
        endcase
    end

    assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_comb begin
        state_next  = state_reg;
        w_next      = w_reg;
        zer_next    = zer_reg;
        neg_next    = neg_reg;
        ovf_next    = ovf_reg;
        done_next   = 1'b0;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE, EXEC: begin
                state_next = IDLE;
                if (start) begin
                    if (opc == 4'd8) begin
                        acc_next    = '0;
                        mcand_next  = in_a;
                        mplier_next = in_b;
                        cnt_next    = '0;
                        state_next  = MUL;
                    end else begin
                        w_next     = alu_res;
                        zer_next   = (alu_res == '0);
                        neg_next   = alu_res[W-1];
                        ovf_next   = alu_ovf;
                        done_next  = 1'b1;
                        state_next = EXEC;
                    end
                end
            end
            MUL: begin
                acc_next    = acc_sum;
                mcand_next  = {mcand_reg[W-2:0], 1'b0};
                mplier_next = {1'b0, mplier_reg[W-1:1]};
                cnt_next    = cnt_reg + CNT_ONE;
                if (cnt_reg == LAST) begin
                    // Low W bits of the unsigned product need no sign fix-up.
                    w_next     = acc_sum;
                    zer_next   = (acc_sum == '0);
                    neg_next   = acc_sum[W-1];
                    ovf_next   = 1'b0;
                    done_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            w_reg      <= '0;
            zer_reg    <= 1'b1;
            neg_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            w_reg      <= w_next;
            zer_reg    <= zer_next;
            neg_reg    <= neg_next;
            ovf_reg    <= ovf_next;
            done_reg   <= done_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign w    = w_reg;
    assign zer  = zer_reg;
    assign neg  = neg_reg;
    assign ovf  = ovf_reg;
    assign done = done_reg;
    assign busy = (state_reg == MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed W=16 scenarios, then a randomized sweep of all
// opcodes on W=16, W=8 and W=32 instances against an integer reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        inc = 1'b0;
    logic [3:0]  opc = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic [15:0] w16;
    logic [7:0]  w8;
    logic [31:0] w32;
    logic zer16, neg16, ovf16, busy16, done16;
    logic zer8,  neg8,  ovf8,  busy8,  done8;
    logic zer32, neg32, ovf32, busy32, done32;

    logic [31:0] ow [3];
    logic        oz [3], on [3], oo [3], ob [3], od [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_seq #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .start(start), .in_a(a[15:0]), .in_b(b[15:0]),
        .opc(opc), .inc(inc), .w(w16), .zer(zer16), .neg(neg16), .ovf(ovf16), .busy(busy16), .done(done16));
    alu_seq #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start), .in_a(a[7:0]), .in_b(b[7:0]),
        .opc(opc), .inc(inc), .w(w8), .zer(zer8), .neg(neg8), .ovf(ovf8), .busy(busy8), .done(done8));
    alu_seq #(.W(32)) dut32 (.clk(clk), .rst_n(rst_n), .start(start), .in_a(a), .in_b(b),
        .opc(opc), .inc(inc), .w(w32), .zer(zer32), .neg(neg32), .ovf(ovf32), .busy(busy32), .done(done32));

    assign ow[0] = {16'h0, w16};
    assign ow[1] = {24'h0, w8};
    assign ow[2] = w32;
    assign oz[0] = zer16; assign oz[1] = zer8; assign oz[2] = zer32;
    assign on[0] = neg16; assign on[1] = neg8; assign on[2] = neg32;
    assign oo[0] = ovf16; assign oo[1] = ovf8; assign oo[2] = ovf32;
    assign ob[0] = busy16; assign ob[1] = busy8; assign ob[2] = busy32;
    assign od[0] = done16; assign od[1] = done8; assign od[2] = done32;

    // Reference: signed integer arithmetic, overflow = true result out of range.
    function automatic logic [32:0] model(input int wd, input logic [3:0] op,
                                          input logic [31:0] aa, input logic [31:0] bb, input logic ci);
        longint one = 1;
        longint mask = (one << wd) - 1;
        longint ua = longint'(aa) & mask;
        longint ub = longint'(bb) & mask;
        longint sa = (ua >= (one << (wd - 1))) ? ua - (one << wd) : ua;
        longint sb = (ub >= (one << (wd - 1))) ? ub - (one << wd) : ub;
        longint maxv = (one << (wd - 1)) - 1;
        longint minv = -(one << (wd - 1));
        longint hm = (one << (wd / 2)) - 1;
        longint r = 0;
        logic o = 1'b0;
        case (op)
            4'd0: begin r = -sa; o = (r > maxv); end
            4'd1: begin r = sa + 1; o = (r > maxv); end
            4'd2: begin r = sa + sb + longint'(ci); o = (r > maxv) || (r < minv); end
            4'd3: begin r = sa + (sb >>> 1); o = (r > maxv) || (r < minv); end
            4'd4: r = ua & ub;
            4'd5: r = ua | ub;
            4'd6: r = ((ua & hm) << (wd / 2)) | (ub & hm);
            4'd8: r = ua * ub;
            default: r = 0;
        endcase
        r = r & mask;
        return {o, r[31:0]};
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb, input logic ci);
        opc = op; a = aa; b = bb; inc = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        int dn = 0;
        issue(4'd2, 32'h1234, 32'h0001, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({w16, zer16, neg16, ovf16, busy16, done16} !== {16'h0000, 5'b10000}) begin
            fails++;
            $display("FAIL reset_state: got w=%h z%b n%b o%b b%b d%b, expected w=0000 z1 n0 o0 b0 d0",
                     w16, zer16, neg16, ovf16, busy16, done16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (done16) dn++;
        end
        tests++;
        if (dn !== 0) begin fails++; $display("FAIL reset_idle_done: got %0d dones, expected 0", dn); end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] va;
        logic [15:0] vb;
        logic        ci;
        logic [15:0] ew;
        logic        eo;
    } vec_t;

    task automatic test_single();
        vec_t v [6] = '{
            '{4'd2, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b1},
            '{4'd0, 16'h8000, 16'h0000, 1'b0, 16'h8000, 1'b1},
            '{4'd6, 16'h12AB, 16'h34CD, 1'b0, 16'hABCD, 1'b0},
            '{4'd3, 16'h0001, 16'hFFFC, 1'b0, 16'hFFFF, 1'b0},
            '{4'd4, 16'h5555, 16'h5555, 1'b0, 16'h5555, 1'b0},
            '{4'd5, 16'h5555, 16'h5555, 1'b0, 16'h5555, 1'b0}
        };
        for (int i = 0; i < 6; i++) begin
            issue(v[i].op, {16'h0, v[i].va}, {16'h0, v[i].vb}, v[i].ci);
            tests++;
            if ({w16, zer16, neg16, ovf16, done16} !== {v[i].ew, v[i].ew == 16'h0, v[i].ew[15], v[i].eo, 1'b1}) begin
                fails++;
                $display("FAIL single_op%0d: got w=%h z%b n%b o%b d%b, expected w=%h o%b d1",
                         v[i].op, w16, zer16, neg16, ovf16, done16, v[i].ew, v[i].eo);
            end
            @(posedge clk); #1;
            tests++;
            if (done16 !== 1'b0) begin fails++; $display("FAIL single_done_pulse%0d: got done=%b, expected 0", i, done16); end
        end
    endtask

    task automatic test_back_to_back();
        opc = 4'd1; a = 32'hFFFF; b = '0; inc = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({w16, zer16, done16} !== {16'h0000, 2'b11}) begin
            fails++; $display("FAIL b2b_first: got w=%h z%b d%b, expected w=0000 z1 d1", w16, zer16, done16);
        end
        opc = 4'd7; a = 32'h1111;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if ({w16, zer16, done16} !== {16'h0000, 2'b11}) begin
            fails++; $display("FAIL b2b_second: got w=%h z%b d%b, expected w=0000 z1 d1", w16, zer16, done16);
        end
        @(posedge clk); #1;
        tests++;
        if (done16 !== 1'b0) begin fails++; $display("FAIL b2b_end: got done=%b, expected 0", done16); end
    endtask

    task automatic run_mul(input logic [15:0] ma, input logic [15:0] mb, input logic [15:0] ew);
        int dn = 0;
        int lat = -1;
        bit clash = 1'b0;
        issue(4'd8, {16'h0, ma}, {16'h0, mb}, 1'b0);
        tests++;
        if (busy16 !== 1'b1) begin fails++; $display("FAIL mul_busy: got busy=%b, expected 1", busy16); end
        for (int s = 1; s <= 22; s++) begin
            @(posedge clk); #1;
            if (done16) begin dn++; if (lat < 0) lat = s; end
            if (done16 && busy16) clash = 1'b1;
            if (s == 4) begin a = $urandom; b = $urandom; opc = 4'd8; start = 1'b1; end
            if (s == 5) start = 1'b0;
        end
        tests++;
        if (dn !== 1 || lat !== 16 || clash) begin
            fails++; $display("FAIL mul_timing: got %0d dones, latency %0d, clash %b, expected 1, 16, 0", dn, lat, clash);
        end
        tests++;
        if ({w16, zer16, neg16, ovf16} !== {ew, ew == 16'h0, ew[15], 1'b0}) begin
            fails++; $display("FAIL mul_result: got w=%h z%b n%b o%b, expected w=%h z%b n%b o0",
                              w16, zer16, neg16, ovf16, ew, ew == 16'h0, ew[15]);
        end
    endtask

    task automatic test_mul();
        run_mul(16'hFFFD, 16'h0007, 16'hFFEB);
        run_mul(16'h0100, 16'h0100, 16'h0000);
    endtask

    task automatic test_mul_reset();
        int dn = 0;
        issue(4'd5, 32'h1234, 32'h0000, 1'b0);
        issue(4'd8, 32'h0003, 32'h0005, 1'b0);
        repeat (8) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy16, done16, w16, zer16} !== {2'b00, 16'h0000, 1'b1}) begin
            fails++; $display("FAIL mulrst_state: got b%b d%b w=%h z%b, expected b0 d0 w=0000 z1", busy16, done16, w16, zer16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (done16) dn++;
        end
        tests++;
        if (dn !== 0 || w16 !== 16'h0000) begin
            fails++; $display("FAIL mulrst_after: got %0d dones w=%h, expected 0 dones w=0000", dn, w16);
        end
        run_mul(16'h1234, 16'h0010, 16'h2340);
    endtask

    task automatic test_sweep();
        rst_n = 1'b0; #2; rst_n = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 64; n++) begin
            logic [3:0]  op = 4'(n);
            logic [31:0] ra = $urandom;
            logic [31:0] rb = $urandom;
            logic        rc = 1'($urandom);
            int          dn [3] = '{0, 0, 0};
            int          lat [3] = '{-1, -1, -1};
            logic [31:0] gw [3];
            logic        gz [3], gn [3], go [3];
            bit          clash = 1'b0;
            issue(op, ra, rb, rc);
            for (int s = 0; s <= 40; s++) begin
                for (int d = 0; d < 3; d++) begin
                    if (od[d] && ob[d]) clash = 1'b1;
                    if (od[d]) begin
                        dn[d]++;
                        if (lat[d] < 0) begin
                            lat[d] = s; gw[d] = ow[d]; gz[d] = oz[d]; gn[d] = on[d]; go[d] = oo[d];
                        end
                    end
                end
                if (s < 40) begin @(posedge clk); #1; end
            end
            tests++;
            if (clash) begin fails++; $display("FAIL sweep_busy_done op%0d: got busy&done together, expected never", op); end
            for (int d = 0; d < 3; d++) begin
                int          wd = (d == 0) ? 16 : (d == 1) ? 8 : 32;
                logic [32:0] m = model(wd, op, ra, rb, rc);
                logic [31:0] ew = m[31:0];
                int          el = (op == 4'd8) ? wd : 0;
                tests++;
                if (dn[d] !== 1 || lat[d] !== el) begin
                    fails++; $display("FAIL sweep_timing W%0d op%0d: got %0d dones latency %0d, expected 1 latency %0d",
                                      wd, op, dn[d], lat[d], el);
                end else begin
                    tests++;
                    if ({gw[d], gz[d], gn[d], go[d]} !== {ew, ew == 32'h0, ew[wd-1], m[32]}) begin
                        fails++; $display("FAIL sweep_result W%0d op%0d a=%h b=%h c%b: got w=%h z%b n%b o%b, expected w=%h z%b n%b o%b",
                                          wd, op, ra, rb, rc, gw[d], gz[d], gn[d], go[d], ew, ew == 32'h0, ew[wd-1], m[32]);
                    end
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_mul();
        test_mul_reset();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
